// File: rtl/arb_pkg.sv
// Shared arbitration types and the rotating-priority search used by rr_arb4_enc.
package arb_pkg;

    localparam int NREQ   = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // First asserted request at or after ptr, wrapping modulo NREQ.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        pick_t      res;
        logic [1:0] k;
        res = '0;
        // Walk from the farthest offset down so the nearest match is written last.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = ptr + 2'(i);
            if (req[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/S4x2encoder.sv
// Structural 4-to-2 OR encoder; valid only for one-hot or all-zero inputs.
module S4x2encoder (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic o0,
    output logic o1
);

    // Input 0 encodes to 2'b00, so it contributes to neither output.
    logic unused_i0;
    assign unused_i0 = i0;

    or g_o0 (o0, i1, i3);
    or g_o1 (o1, i2, i3);

endmodule

// File: rtl/rr_arb4_enc.sv
// Four-requester round-robin arbiter with bounded hold and encoded grant index.
import arb_pkg::*;

module rr_arb4_enc #(
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      gnt_idx,
    output logic            gnt_valid
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic  own_req;
    pick_t pick_any;
    pick_t pick_other;

    assign own_req    = |(req & gnt_q);
    assign pick_any   = rr_pick(req, ptr_q);
    // Excluding the owner makes it eligible at expiry only when nobody else waits.
    assign pick_other = rr_pick(req & ~gnt_q, ptr_q);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any.found) begin
                    state_d    = BUSY;
                    gnt_d      = NREQ'(1) << pick_any.idx;
                    ptr_d      = pick_any.idx + 2'd1;
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            BUSY: begin
                if (own_req && (hold_cnt_q < MAX_HOLD_C)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (pick_other.found) begin
                    gnt_d      = NREQ'(1) << pick_other.idx;
                    ptr_d      = pick_other.idx + 2'd1;
                    hold_cnt_d = HOLD_W'(1);
                end else if (own_req) begin
                    // Sole requester at expiry: re-grant in place, restart the burst.
                    ptr_d      = gnt_idx + 2'd1;
                    hold_cnt_d = HOLD_W'(1);
                end else begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    hold_cnt_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    S4x2encoder u_enc (
        .i0 (gnt_q[0]),
        .i1 (gnt_q[1]),
        .i2 (gnt_q[2]),
        .i3 (gnt_q[3]),
        .o0 (gnt_idx[0]),
        .o1 (gnt_idx[1])
    );

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == BUSY);

endmodule
